// File: rtl/ex_unit_scheduler_pkg.sv
// rtl/ex_unit_scheduler_pkg.sv - shared constants, state and class encodings for the issue scheduler
package ex_unit_scheduler_pkg;

  localparam logic [6:0] OP_R          = 7'h33;
  localparam logic [6:0] OP_ENC        = 7'h0B;
  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MD_WAIT,
    ST_ENC_REQ,
    ST_ENC_WAIT,
    ST_WB
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MD,
    CLS_ENC
  } op_class_e;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MD  = 2'd1;
  localparam logic [1:0] WB_SEL_ENC = 2'd2;

endpackage

// File: rtl/ex_unit_scheduler_if.sv
// rtl/ex_unit_scheduler_if.sv - decoder, muldiv, accelerator and writeback signals of the issue scheduler
interface ex_unit_scheduler_if;
  logic       dec_valid_i;
  logic [6:0] dec_op_i;
  logic [2:0] dec_funct3_i;
  logic [6:0] dec_funct7_i;
  logic [4:0] dec_rd_i;
  logic       flush_i;
  logic       stall_o;
  logic       ex_issue_o;
  logic       md_start_o;
  logic [2:0] md_funct3_o;
  logic       md_done_i;
  logic       enc_req_o;
  logic       enc_ack_i;
  logic       enc_done_i;
  logic       abort_o;
  logic       wb_valid_o;
  logic [1:0] wb_sel_o;
  logic [4:0] wb_rd_o;
  logic       wb_we_o;
  logic       err_o;

  modport master (
    input  dec_valid_i, dec_op_i, dec_funct3_i, dec_funct7_i, dec_rd_i, flush_i,
           md_done_i, enc_ack_i, enc_done_i,
    output stall_o, ex_issue_o, md_start_o, md_funct3_o, enc_req_o, abort_o,
           wb_valid_o, wb_sel_o, wb_rd_o, wb_we_o, err_o
  );

  modport slave (
    output dec_valid_i, dec_op_i, dec_funct3_i, dec_funct7_i, dec_rd_i, flush_i,
           md_done_i, enc_ack_i, enc_done_i,
    input  stall_o, ex_issue_o, md_start_o, md_funct3_o, enc_req_o, abort_o,
           wb_valid_o, wb_sel_o, wb_rd_o, wb_we_o, err_o
  );
endinterface

// File: rtl/ex_class_decode.sv
// rtl/ex_class_decode.sv - classify a decoded instruction as ALU, MULDIV or encryption
module ex_class_decode
  import ex_unit_scheduler_pkg::*;
#(
  parameter logic [6:0] ENC_OPCODE = OP_ENC
) (
  input  logic [6:0] op_i,
  input  logic [6:0] funct7_i,
  output op_class_e  class_o
);

  always_comb begin
    class_o = CLS_ALU;
    if (op_i == ENC_OPCODE) begin
      class_o = CLS_ENC;
    end else if (op_i == OP_R && funct7_i == FUNCT7_MULDIV) begin
      class_o = CLS_MD;
    end
  end

endmodule

// File: rtl/ex_unit_scheduler.sv
// rtl/ex_unit_scheduler.sv - issue controller sequencing multi-cycle MULDIV/ENC ops with flush and watchdog abort
module ex_unit_scheduler
  import ex_unit_scheduler_pkg::*;
#(
  parameter logic [6:0] ENC_OPCODE = OP_ENC,
  parameter int         TIMEOUT    = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  ex_unit_scheduler_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rd_q, rd_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    sel_q, sel_d;
  op_class_e     cls;
  logic          expired;

  ex_class_decode #(.ENC_OPCODE(ENC_OPCODE)) u_class_decode (
    .op_i     (bus.dec_op_i),
    .funct7_i (bus.dec_funct7_i),
    .class_o  (cls)
  );

  assign expired         = (cnt_q == CNT_LAST);
  assign bus.md_funct3_o = funct3_q;
  assign bus.wb_rd_o     = rd_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
      sel_q    <= WB_SEL_ALU;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      funct3_q <= funct3_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rd_d           = rd_q;
    funct3_d       = funct3_q;
    sel_d          = sel_q;
    bus.stall_o    = 1'b1;
    bus.ex_issue_o = 1'b0;
    bus.md_start_o = 1'b0;
    bus.enc_req_o  = 1'b0;
    bus.abort_o    = 1'b0;
    bus.err_o      = 1'b0;
    bus.wb_valid_o = 1'b0;
    bus.wb_sel_o   = WB_SEL_ALU;
    bus.wb_we_o    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bus.stall_o = 1'b0;
        cnt_d       = '0;
        if (bus.dec_valid_i && !bus.flush_i) begin
          unique case (cls)
            CLS_MD: begin
              bus.stall_o = 1'b1;
              rd_d        = bus.dec_rd_i;
              funct3_d    = bus.dec_funct3_i;
              sel_d       = WB_SEL_MD;
              state_d     = ST_MD_WAIT;
            end
            CLS_ENC: begin
              bus.stall_o = 1'b1;
              rd_d        = bus.dec_rd_i;
              sel_d       = WB_SEL_ENC;
              state_d     = ST_ENC_REQ;
            end
            default: bus.ex_issue_o = 1'b1;
          endcase
        end
      end

      // The counter is cleared on entry, so a zero count marks the first MD_WAIT cycle.
      ST_MD_WAIT: begin
        bus.md_start_o = (cnt_q == '0) && !bus.flush_i;
        cnt_d          = cnt_q + 1'b1;
        if (bus.flush_i) begin
          bus.abort_o = 1'b1;
          state_d     = ST_IDLE;
        end else if (bus.md_done_i) begin
          state_d = ST_WB;
        end else if (expired) begin
          bus.err_o   = 1'b1;
          bus.abort_o = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_ENC_REQ: begin
        bus.enc_req_o = !bus.flush_i;
        cnt_d         = cnt_q + 1'b1;
        if (bus.flush_i) begin
          bus.abort_o = 1'b1;
          state_d     = ST_IDLE;
        end else if (bus.enc_ack_i && bus.enc_done_i) begin
          state_d = ST_WB;
        end else if (expired) begin
          bus.err_o   = 1'b1;
          bus.abort_o = 1'b1;
          state_d     = ST_IDLE;
        end else if (bus.enc_ack_i) begin
          state_d = ST_ENC_WAIT;
        end
      end

      ST_ENC_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.flush_i) begin
          bus.abort_o = 1'b1;
          state_d     = ST_IDLE;
        end else if (bus.enc_done_i) begin
          state_d = ST_WB;
        end else if (expired) begin
          bus.err_o   = 1'b1;
          bus.abort_o = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_WB: begin
        state_d = ST_IDLE;
        if (bus.flush_i) begin
          bus.abort_o = 1'b1;
        end else begin
          bus.wb_valid_o = 1'b1;
          bus.wb_sel_o   = sel_q;
          bus.wb_we_o    = (rd_q != 5'd0);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ex_unit_scheduler.sv
// tb/tb_ex_unit_scheduler.sv - directed scoreboard bench for ex_unit_scheduler
module tb_ex_unit_scheduler;

    typedef struct {
        logic [1:0] sel;
        logic [4:0] rd;
        logic       we;
    } wb_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    wb_t  exp_q[$];
    wb_t  got;

    always #5 clock = ~clock;

    ex_unit_scheduler_if bus ();

    ex_unit_scheduler #(.ENC_OPCODE(7'h0B), .TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && bus.wb_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", bus.wb_valid_o, 1'b0);
            end else begin
                got = exp_q.pop_front();
                chk("wb_sel", bus.wb_sel_o, got.sel);
                chk("wb_rd", bus.wb_rd_o, got.rd);
                chk("wb_we", bus.wb_we_o, got.we);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins);
        bus.dec_valid_i  = 1'b1;
        bus.dec_op_i     = ins[6:0];
        bus.dec_rd_i     = ins[11:7];
        bus.dec_funct3_i = ins[14:12];
        bus.dec_funct7_i = ins[31:25];
    endtask

    task automatic no_dec();
        bus.dec_valid_i = 1'b0;
    endtask

    initial begin
        bus.dec_valid_i  = 1'b0;
        bus.dec_op_i     = '0;
        bus.dec_funct3_i = '0;
        bus.dec_funct7_i = '0;
        bus.dec_rd_i     = '0;
        bus.flush_i      = 1'b0;
        bus.md_done_i    = 1'b0;
        bus.enc_ack_i    = 1'b0;
        bus.enc_done_i   = 1'b0;

        step();
        chk("rst_stall", bus.stall_o, 1'b0);
        chk("rst_issue", bus.ex_issue_o, 1'b0);
        chk("rst_md_start", bus.md_start_o, 1'b0);
        chk("rst_enc_req", bus.enc_req_o, 1'b0);
        chk("rst_abort", bus.abort_o, 1'b0);
        chk("rst_err", bus.err_o, 1'b0);
        chk("rst_wb_valid", bus.wb_valid_o, 1'b0);
        chk("rst_wb_sel", bus.wb_sel_o, 2'd0);
        chk("rst_wb_rd", bus.wb_rd_o, 5'd0);
        chk("rst_funct3", bus.md_funct3_o, 3'd0);
        reset = 1'b0;

        step(); issue(32'h40208233); #3;
        chk("alu_issue", bus.ex_issue_o, 1'b1);
        chk("alu_stall", bus.stall_o, 1'b0);
        chk("alu_wb", bus.wb_valid_o, 1'b0);

        step(); issue(32'h02220233); exp_q.push_back('{2'd1, 5'd4, 1'b1}); #3;
        chk("mul_c0_stall", bus.stall_o, 1'b1);
        chk("mul_c0_issue", bus.ex_issue_o, 1'b0);
        step(); no_dec(); #3;
        chk("mul_c1_start", bus.md_start_o, 1'b1);
        chk("mul_c1_funct3", bus.md_funct3_o, 3'd0);
        step(); #3;
        chk("mul_c2_start", bus.md_start_o, 1'b0);
        chk("mul_c2_stall", bus.stall_o, 1'b1);
        step();
        step(); bus.md_done_i = 1'b1; #3;
        chk("mul_c4_wb", bus.wb_valid_o, 1'b0);
        step(); bus.md_done_i = 1'b0; #3;
        chk("mul_c5_wb", bus.wb_valid_o, 1'b1);
        chk("mul_c5_stall", bus.stall_o, 1'b1);
        step(); #3;
        chk("mul_c6_stall", bus.stall_o, 1'b0);
        chk("mul_c6_wb", bus.wb_valid_o, 1'b0);

        step(); issue(32'h0032408B); exp_q.push_back('{2'd2, 5'd1, 1'b1}); #3;
        chk("enc_c0_stall", bus.stall_o, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            step(); no_dec(); bus.enc_ack_i = (c == 3); #3;
            chk("enc_req_high", bus.enc_req_o, 1'b1);
        end
        step(); bus.enc_ack_i = 1'b0; #3;
        chk("enc_c4_req", bus.enc_req_o, 1'b0);
        chk("enc_c4_stall", bus.stall_o, 1'b1);
        step();
        step(); bus.enc_done_i = 1'b1; #3;
        chk("enc_c6_wb", bus.wb_valid_o, 1'b0);
        step(); bus.enc_done_i = 1'b0; #3;
        chk("enc_c7_wb", bus.wb_valid_o, 1'b1);
        step(); #3;
        chk("enc_c8_stall", bus.stall_o, 1'b0);

        step(); issue(32'h0000000B); exp_q.push_back('{2'd2, 5'd0, 1'b0}); #3;
        step(); no_dec(); bus.enc_ack_i = 1'b1; #3;
        step(); bus.enc_ack_i = 1'b0; bus.enc_done_i = 1'b1; #3;
        step(); bus.enc_done_i = 1'b0; #3;
        chk("enc0_wb", bus.wb_valid_o, 1'b1);
        chk("enc0_we", bus.wb_we_o, 1'b0);
        step(); #3;

        step(); issue(32'h02324433); #3;
        step(); no_dec(); #3;
        chk("div_start", bus.md_start_o, 1'b1);
        chk("div_funct3", bus.md_funct3_o, 3'd4);
        step();
        step(); bus.flush_i = 1'b1; bus.md_done_i = 1'b1; #3;
        chk("div_abort", bus.abort_o, 1'b1);
        chk("div_c3_wb", bus.wb_valid_o, 1'b0);
        step(); bus.flush_i = 1'b0; bus.md_done_i = 1'b0; #3;
        chk("div_c4_stall", bus.stall_o, 1'b0);
        chk("div_c4_abort", bus.abort_o, 1'b0);
        chk("div_c4_wb", bus.wb_valid_o, 1'b0);

        step(); issue(32'h02326533); #3;
        for (int c = 1; c <= 7; c++) begin
            step(); no_dec(); #3;
            chk("rem_no_err", bus.err_o, 1'b0);
            chk("rem_no_abort", bus.abort_o, 1'b0);
        end
        step(); #3;
        chk("rem_err", bus.err_o, 1'b1);
        chk("rem_abort", bus.abort_o, 1'b1);
        chk("rem_wb", bus.wb_valid_o, 1'b0);
        step(); #3;
        chk("rem_c9_stall", bus.stall_o, 1'b0);
        chk("rem_c9_err", bus.err_o, 1'b0);

        step(); issue(32'h40208233); bus.flush_i = 1'b1; #3;
        chk("idle_flush_issue", bus.ex_issue_o, 1'b0);
        step(); issue(32'h02220233); #3;
        chk("idle_flush_md_stall", bus.stall_o, 1'b0);
        step(); no_dec(); bus.flush_i = 1'b0; #3;
        chk("idle_flush_state", bus.stall_o, 1'b0);

        step(); issue(32'h02220233); #3;
        step(); no_dec(); bus.md_done_i = 1'b1; #3;
        step(); bus.md_done_i = 1'b0; bus.flush_i = 1'b1; #3;
        chk("wbflush_abort", bus.abort_o, 1'b1);
        chk("wbflush_wb", bus.wb_valid_o, 1'b0);
        step(); bus.flush_i = 1'b0; #3;
        chk("wbflush_idle", bus.stall_o, 1'b0);

        step(); issue(32'h0000018B); exp_q.push_back('{2'd2, 5'd3, 1'b1}); #3;
        step(); no_dec(); #3;
        chk("encfast_req", bus.enc_req_o, 1'b1);
        step(); bus.enc_ack_i = 1'b1; bus.enc_done_i = 1'b1; #3;
        chk("encfast_c2_wb", bus.wb_valid_o, 1'b0);
        step(); bus.enc_ack_i = 1'b0; bus.enc_done_i = 1'b0; #3;
        chk("encfast_c3_wb", bus.wb_valid_o, 1'b1);

        step(); issue(32'h02220233); #3;
        step(); no_dec(); #3;
        chk("rstmid_start", bus.md_start_o, 1'b1);
        chk("rstmid_rd_before", bus.wb_rd_o, 5'd4);
        step(); #3;
        reset = 1'b1; #1;
        chk("rstmid_stall", bus.stall_o, 1'b0);
        chk("rstmid_abort", bus.abort_o, 1'b0);
        chk("rstmid_rd", bus.wb_rd_o, 5'd0);
        chk("rstmid_wb", bus.wb_valid_o, 1'b0);
        step(); reset = 1'b0;
        step(); #3;
        chk("rstmid_idle", bus.stall_o, 1'b0);
        chk("rstmid_start_after", bus.md_start_o, 1'b0);

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
